// File: rtl/mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader_pkg
// Brief    : Shared types and constants for the boot-image memory loader.
// Revision : 1.0 - initial release
// ============================================================================
package mem_loader_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // Length header is a 32-bit little-endian word
    localparam int unsigned c_hdr_bytes = 4;

    // Default load window
    localparam logic [15:0] c_base_addr = 16'h0000;
    localparam int unsigned c_mem_bytes = 32'h0001_0000;

endpackage
`default_nettype wire

// File: rtl/mem_loader_pack.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader_pack
// Brief    : 64-bit byte-lane pack register with accumulated byte strobes.
//            Unwritten lanes stay zero so a short final word is clean.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_wr,
    input  logic [2:0]  i_lane,
    input  logic [7:0]  i_byte,
    output logic [63:0] o_data,
    output logic [7:0]  o_strb
);

    logic [63:0] r_data;
    logic [7:0]  r_strb;

    // Drop a byte into its lane and mark the lane; clear after each write
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_data <= 64'd0;
            r_strb <= 8'd0;
        end else if (i_wr) begin
            r_data[{i_lane, 3'b000} +: 8] <= i_byte;
            r_strb[i_lane]                <= 1'b1;
        end
    end

    assign o_data = r_data;
    assign o_strb = r_strb;

endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Brief    : Streams a length-prefixed byte image into memory as 8-byte
//            words, then releases the CPU from reset. Oversized images are
//            rejected before any write is issued.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = c_base_addr,
    parameter int unsigned MEM_BYTES = c_mem_bytes
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_ready,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_len;
    logic [31:0] r_byte_cnt;
    logic [1:0]  r_hdr_cnt;
    logic [15:0] r_addr;
    logic        r_done;
    logic        r_err;

    logic        w_s_hs;
    logic        w_hdr_last;
    logic [31:0] w_len_full;
    logic        w_len_zero;
    logic        w_len_big;
    logic        w_data_acc;
    logic        w_data_last;
    logic        w_wr_done;
    logic        w_all_sent;

    assign s_ready    = (r_state == ST_LEN) || (r_state == ST_DATA);
    assign w_s_hs     = s_valid && s_ready;
    assign w_hdr_last = (r_state == ST_LEN) && w_s_hs &&
                        (r_hdr_cnt == 2'(c_hdr_bytes - 1));
    // Full length as it will be once the last header byte lands
    assign w_len_full = {s_data, r_len[23:0]};
    assign w_len_zero = (w_len_full == 32'd0);
    // 33-bit sum so a huge N cannot wrap past the window check
    assign w_len_big  = (({1'b0, w_len_full} + {17'd0, BASE_ADDR}) > 33'(MEM_BYTES));
    assign w_data_acc = (r_state == ST_DATA) && w_s_hs;
    assign w_data_last = ((r_byte_cnt + 32'd1) == r_len);
    assign w_wr_done  = (r_state == ST_WRITE) && mem_ready;
    assign w_all_sent = (r_byte_cnt == r_len);

    assign mem_we   = (r_state == ST_WRITE);
    assign mem_addr = r_addr;
    assign cpu_rst  = !((r_state == ST_FIN) && r_done);
    assign done     = r_done;
    assign err      = r_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_LEN;
            ST_LEN:   if (w_hdr_last) begin
                          if (w_len_zero || w_len_big) w_state_nxt = ST_FIN;
                          else                         w_state_nxt = ST_DATA;
                      end
            ST_DATA:  if (w_data_acc && ((r_byte_cnt[2:0] == 3'd7) || w_data_last))
                          w_state_nxt = ST_WRITE;
            ST_WRITE: if (mem_ready) w_state_nxt = w_all_sent ? ST_FIN : ST_DATA;
            ST_FIN:   w_state_nxt = ST_FIN;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Header capture, byte counting, address advance and sticky status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= 32'd0;
            r_byte_cnt <= 32'd0;
            r_hdr_cnt  <= 2'd0;
            r_addr     <= BASE_ADDR;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if ((r_state == ST_LEN) && w_s_hs) begin
                r_len[{r_hdr_cnt, 3'b000} +: 8] <= s_data;
                r_hdr_cnt                       <= r_hdr_cnt + 2'd1;
            end
            if (w_hdr_last) begin
                if (w_len_zero)     r_done <= 1'b1;
                else if (w_len_big) r_err  <= 1'b1;
            end
            if (w_data_acc) r_byte_cnt <= r_byte_cnt + 32'd1;
            if (w_wr_done) begin
                r_addr <= r_addr + 16'd8;
                if (w_all_sent) r_done <= 1'b1;
            end
        end
    end

    mem_loader_pack u_pack (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_wr_done),
        .i_wr   (w_data_acc),
        .i_lane (r_byte_cnt[2:0]),
        .i_byte (s_data),
        .o_data (mem_wdata),
        .o_strb (mem_wstrb)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_loader
// Brief    : Scoreboard bench for mem_loader; directed streams with
//            hand-computed expected memory writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_loader;
    import mem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ready = 1'b1;
    logic        cpu_rst;
    logic        done;
    logic        err;

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } wr_t;

    wr_t sb[$];
    int  n_pass = 0;
    int  n_total = 0;

    mem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: pops expected writes on each handshake, checks hold-stability
    logic        stall_seen = 1'b0;
    logic [15:0] h_addr;
    logic [63:0] h_data;
    logic [7:0]  h_strb;
    always @(negedge clk) begin
        if (rst) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                chk("stall_addr", mem_addr, h_addr);
                chk("stall_data", mem_wdata, h_data);
                chk("stall_strb", mem_wstrb, h_strb);
                chk("stall_s_ready", s_ready, 0);
            end
            stall_seen = 1'b0;
            if (mem_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_mem_we", mem_we, 0);
                end else if (mem_ready) begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("wr_addr", mem_addr, e.addr);
                    chk("wr_data", mem_wdata, e.data);
                    chk("wr_strb", mem_wstrb, e.strb);
                end else begin
                    stall_seen = 1'b1;
                    h_addr = mem_addr;
                    h_data = mem_wdata;
                    h_strb = mem_wstrb;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_state", dut.r_state, ST_IDLE);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        s_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic send_hdr(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(8'(n >> (8 * i)));
    endtask

    task automatic send_bytes(input logic [7:0] first, input int cnt);
        for (int i = 0; i < cnt; i++) send_byte(first + 8'(i));
    endtask

    task automatic wait_end(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done || err) seen = 1'b1;
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic push_16word();
        sb.push_back('{16'h0000, 64'h0706050403020100, 8'hFF});
        sb.push_back('{16'h0008, 64'h0F0E0D0C0B0A0908, 8'hFF});
    endtask

    task automatic check_ok_end(input string name);
        wait_end(name);
        chk({name, "_done"}, done, 1);
        chk({name, "_err"}, err, 0);
        chk({name, "_cpu_rst"}, cpu_rst, 0);
        chk({name, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        // Two full words, free-running memory
        do_reset();
        push_16word();
        send_hdr(32'd16);
        send_bytes(8'h00, 16);
        check_ok_end("n16");

        // Short final word
        do_reset();
        sb.push_back('{16'h0000, 64'hB1B0AFAEADACABAA, 8'hFF});
        sb.push_back('{16'h0008, 64'h0000000000B4B3B2, 8'h07});
        send_hdr(32'd11);
        send_bytes(8'hAA, 11);
        check_ok_end("n11");

        // Empty payload
        do_reset();
        send_hdr(32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("n0_done", done, 1);
        chk("n0_cpu_rst", cpu_rst, 0);
        chk("n0_s_ready", s_ready, 0);

        // Oversized payload rejected
        do_reset();
        send_hdr(32'h0001_0001);
        s_valid = 1'b1;
        s_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("big_err", err, 1);
            chk("big_done", done, 0);
            chk("big_cpu_rst", cpu_rst, 1);
            chk("big_s_ready", s_ready, 0);
        end
        s_valid = 1'b0;

        // Memory back-pressure on the first word
        do_reset();
        push_16word();
        mem_ready = 1'b0;
        send_hdr(32'd16);
        send_bytes(8'h00, 8);
        repeat (5) @(posedge clk);
        #1 mem_ready = 1'b1;
        send_bytes(8'h08, 8);
        check_ok_end("stall");

        // Reset while the first write is pending, then full resend
        do_reset();
        push_16word();
        mem_ready = 1'b0;
        send_hdr(32'd16);
        send_bytes(8'h00, 8);
        @(negedge clk);
        chk("pre_rst_mem_we", mem_we, 1);
        do_reset();
        sb.delete();
        mem_ready = 1'b1;
        push_16word();
        send_hdr(32'd16);
        send_bytes(8'h00, 16);
        check_ok_end("resend");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
